// File: rtl/cartoon_pkg.sv
// Shared definitions for the cartoon pipeline.
//   mode_e    : effect select carried through the pipe
//   WHITE_MAX : all-ones source for the edge-map background colour
package cartoon_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_CLASSIC = 2'd1,
        MODE_POSTER  = 2'd2,
        MODE_EDGEMAP = 2'd3
    } mode_e;

    localparam int MAX_DW = 32;
    localparam logic [MAX_DW-1:0] WHITE_MAX = '1;

endpackage

// File: rtl/cartoon_pipe_posterize_ch.sv
// Combinational posterize of one colour channel.
//   x : channel value in
//   y : top QB bits of x replicated downward to fill DW bits
// QB == DW degenerates to a straight copy.
module posterize_ch #(
    parameter int DW = 8,
    parameter int QB = 3
) (
    input  logic [DW-1:0] x,
    output logic [DW-1:0] y
);

    // Bit i takes the kept bit at the same position modulo QB, counted from the MSB.
    for (genvar i = 0; i < DW; i++) begin : g_bit
        assign y[i] = x[DW-1 - ((DW-1-i) % QB)];
    end

endmodule

// File: rtl/cartoon_pipe.sv
// Two-stage cartoon effect pipeline.
//   clk, rst            : pixel clock, synchronous active-high reset
//   en, mode            : effect enable (per pixel) and effect mode (shadowed)
//   edge_thresh         : edge when cartoon_edge > threshold (shadowed)
//   edge_color          : {R,G,B} painted on edge pixels (shadowed)
//   in_valid, in_sof    : input qualifier / first pixel of frame
//   r, g, b             : camera pixel
//   cartoon_edge/_blur  : edge magnitude and blurred pixel
//   pass_in/pass_thru   : sideband, delayed with the pixel
//   out_valid, out_sof  : output qualifiers, 2 cycles after input
//   outR, outG, outB    : result pixel
//   edge_count          : saturating edge-pixel count of last completed frame
module cartoon_pipe
    import cartoon_pkg::*;
#(
    parameter int DW = 8,
    parameter int EW = 8,
    parameter int QB = 3,
    parameter int PW = 24,
    parameter int CW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [EW-1:0]   edge_thresh,
    input  logic [3*DW-1:0] edge_color,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic [DW-1:0]   r,
    input  logic [DW-1:0]   g,
    input  logic [DW-1:0]   b,
    input  logic [EW-1:0]   cartoon_edge,
    input  logic [3*DW-1:0] cartoon_blur,
    input  logic [PW-1:0]   pass_in,
    output logic            out_valid,
    output logic            out_sof,
    output logic [DW-1:0]   outR,
    output logic [DW-1:0]   outG,
    output logic [DW-1:0]   outB,
    output logic [PW-1:0]   pass_thru,
    output logic [CW-1:0]   edge_count
);

    localparam int STAGES = 2;
    localparam logic [DW-1:0] WHITE = WHITE_MAX[DW-1:0];

    // Frame-start shadow of the configuration
    mode_e          sh_mode;
    logic [EW-1:0]  sh_thresh;
    logic [3*DW-1:0] sh_color;

    logic           load;
    mode_e          eff_mode;
    logic [EW-1:0]  eff_thresh;
    logic [3*DW-1:0] eff_color;

    // The sof pixel itself already runs with the freshly loaded settings.
    assign load = in_valid && in_sof;

    always_comb begin
        eff_mode   = sh_mode;
        eff_thresh = sh_thresh;
        eff_color  = sh_color;
        if (load) begin
            eff_mode   = mode_e'(mode);
            eff_thresh = edge_thresh;
            eff_color  = edge_color;
        end
    end

    // Posterize, one instance per channel ([2]=R, [1]=G, [0]=B)
    logic [2:0][DW-1:0] blur_ch, post_ch;
    assign blur_ch = cartoon_blur;

    for (genvar ch = 0; ch < 3; ch++) begin : g_post
        posterize_ch #(.DW(DW), .QB(QB)) u_post (
            .x (blur_ch[ch]),
            .y (post_ch[ch])
        );
    end

    // Stage 1 registers
    logic [STAGES:1] vld_pipe, sof_pipe;
    logic            s1_en, s1_edge;
    mode_e           s1_mode;
    logic [3*DW-1:0] s1_color, s1_pix, s1_blur, s1_post;
    logic [PW-1:0]   s1_pass;

    // Stage 2 registers
    logic [3*DW-1:0] out_rgb;
    logic [3*DW-1:0] sel;

    always_comb begin
        sel = s1_pix;
        if (s1_en) begin
            case (s1_mode)
                MODE_CLASSIC: sel = s1_edge ? s1_color : s1_blur;
                MODE_POSTER:  sel = s1_edge ? s1_color : s1_post;
                MODE_EDGEMAP: sel = s1_edge ? s1_color : {3{WHITE}};
                default:      sel = s1_pix;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode   <= MODE_BYPASS;
            sh_thresh <= '0;
            sh_color  <= '0;
            vld_pipe  <= '0;
            sof_pipe  <= '0;
            s1_en     <= 1'b0;
            s1_edge   <= 1'b0;
            s1_mode   <= MODE_BYPASS;
            s1_color  <= '0;
            s1_pix    <= '0;
            s1_blur   <= '0;
            s1_post   <= '0;
            s1_pass   <= '0;
            out_rgb   <= '0;
            pass_thru <= '0;
        end else begin
            if (load) begin
                sh_mode   <= eff_mode;
                sh_thresh <= eff_thresh;
                sh_color  <= eff_color;
            end
            vld_pipe  <= {vld_pipe[1], in_valid};
            sof_pipe  <= {sof_pipe[1], in_valid && in_sof};
            s1_en     <= en;
            s1_edge   <= cartoon_edge > eff_thresh;
            s1_mode   <= eff_mode;
            s1_color  <= eff_color;
            s1_pix    <= {r, g, b};
            s1_blur   <= cartoon_blur;
            s1_post   <= post_ch;
            s1_pass   <= pass_in;
            out_rgb   <= sel;
            pass_thru <= s1_pass;
        end
    end

    assign out_valid = vld_pipe[2];
    assign out_sof   = sof_pipe[2];
    assign outR      = out_rgb[3*DW-1 -: DW];
    assign outG      = out_rgb[2*DW-1 -: DW];
    assign outB      = out_rgb[DW-1:0];

    // Edge counter runs off stage 1 so edge_count moves together with out_sof.
    // Edges are counted regardless of en or mode.
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt    <= '0;
            edge_count <= '0;
        end else if (vld_pipe[1] && sof_pipe[1]) begin
            edge_count <= run_cnt;
            run_cnt    <= s1_edge ? CW'(1) : '0;
        end else if (vld_pipe[1] && s1_edge && (run_cnt != '1)) begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_cartoon_pipe.sv
module tb_cartoon_pipe;

    localparam int DW = 8, EW = 8, QB = 3, PW = 24, CW = 20, CW4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b0, en = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
    logic [1:0]      mode = '0;
    logic [EW-1:0]   edge_thresh = '0, cartoon_edge = '0;
    logic [3*DW-1:0] edge_color = '0, cartoon_blur = '0;
    logic [DW-1:0]   r = '0, g = '0, b = '0;
    logic [PW-1:0]   pass_in = '0;

    logic            out_valid, out_sof, out_valid4, out_sof4;
    logic [DW-1:0]   outR, outG, outB, outR4, outG4, outB4;
    logic [PW-1:0]   pass_thru, pass_thru4;
    logic [CW-1:0]   edge_count;
    logic [CW4-1:0]  edge_count4;

    cartoon_pipe #(.DW(DW), .EW(EW), .QB(QB), .PW(PW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .edge_thresh(edge_thresh),
        .edge_color(edge_color), .in_valid(in_valid), .in_sof(in_sof),
        .r(r), .g(g), .b(b), .cartoon_edge(cartoon_edge), .cartoon_blur(cartoon_blur),
        .pass_in(pass_in), .out_valid(out_valid), .out_sof(out_sof),
        .outR(outR), .outG(outG), .outB(outB), .pass_thru(pass_thru),
        .edge_count(edge_count)
    );

    cartoon_pipe #(.DW(DW), .EW(EW), .QB(QB), .PW(PW), .CW(CW4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .edge_thresh(edge_thresh),
        .edge_color(edge_color), .in_valid(in_valid), .in_sof(in_sof),
        .r(r), .g(g), .b(b), .cartoon_edge(cartoon_edge), .cartoon_blur(cartoon_blur),
        .pass_in(pass_in), .out_valid(out_valid4), .out_sof(out_sof4),
        .outR(outR4), .outG(outG4), .outB(outB4), .pass_thru(pass_thru4),
        .edge_count(edge_count4)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    typedef struct {
        logic            v;
        logic            s;
        logic [3*DW-1:0] rgb;
        logic [PW-1:0]   pass;
        int              ec;
    } exp_t;

    exp_t            exp_q[$];
    int              m_mode;
    logic [EW-1:0]   m_thr;
    logic [3*DW-1:0] m_col;
    int              m_run, m_ec;

    function automatic logic [DW-1:0] post(input logic [DW-1:0] x);
        logic [DW-1:0] top, res;
        top = (x >> (DW-QB)) << (DW-QB);
        res = '0;
        for (int k = 0; k < DW; k += QB) res |= top >> k;
        return res;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_thr = '0; m_col = '0; m_run = 0; m_ec = 0;
        exp_q.delete();
        exp_q.push_back('{v: 1'b0, s: 1'b0, rgb: '0, pass: '0, ec: 0});
    endtask

    // One clock: model the current inputs, advance, check the beat now at the output.
    task automatic step();
        exp_t e, o;
        logic ie;
        int   md;
        pass_in = PW'($urandom);
        if (in_valid && in_sof) begin
            m_mode = int'(mode); m_thr = edge_thresh; m_col = edge_color;
        end
        ie = cartoon_edge > m_thr;
        md = en ? m_mode : 0;
        case (md)
            1:       e.rgb = ie ? m_col : cartoon_blur;
            2:       e.rgb = ie ? m_col : {post(cartoon_blur[23:16]), post(cartoon_blur[15:8]),
                                           post(cartoon_blur[7:0])};
            3:       e.rgb = ie ? m_col : 24'hFFFFFF;
            default: e.rgb = {r, g, b};
        endcase
        if (in_valid) begin
            if (in_sof) begin
                m_ec = m_run; m_run = ie ? 1 : 0;
            end else if (ie) begin
                m_run++;
            end
        end
        e.v = in_valid; e.s = in_valid && in_sof; e.pass = pass_in; e.ec = m_ec;
        exp_q.push_back(e);
        @(posedge clk); #1;
        o = exp_q.pop_front();
        checks++;
        if (out_valid !== o.v) begin
            failures++; $display("FAIL out_valid got=%0b exp=%0b t=%0t", out_valid, o.v, $time);
        end
        checks++;
        if (out_sof !== o.s) begin
            failures++; $display("FAIL out_sof got=%0b exp=%0b t=%0t", out_sof, o.s, $time);
        end
        checks++;
        if (pass_thru !== o.pass) begin
            failures++; $display("FAIL pass_thru got=%h exp=%h t=%0t", pass_thru, o.pass, $time);
        end
        checks++;
        if (edge_count !== CW'(sat(o.ec, CW))) begin
            failures++; $display("FAIL edge_count got=%0d exp=%0d t=%0t", edge_count, o.ec, $time);
        end
        checks++;
        if (edge_count4 !== CW4'(sat(o.ec, CW4))) begin
            failures++; $display("FAIL edge_count4 got=%0d exp=%0d t=%0t", edge_count4,
                                 sat(o.ec, CW4), $time);
        end
        if (o.v) begin
            checks++;
            if ({outR, outG, outB} !== o.rgb) begin
                failures++; $display("FAIL pixel got=%h exp=%h t=%0t", {outR, outG, outB}, o.rgb, $time);
            end
        end
    endtask

    task automatic beat(input logic v, input logic s, input logic [EW-1:0] e);
        in_valid = v; in_sof = s; cartoon_edge = e;
        r = DW'($urandom); g = DW'($urandom); b = DW'($urandom);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sof = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        checks++;
        if ({out_valid, out_sof, outR, outG, outB, pass_thru, edge_count, edge_count4} !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%0b s=%0b rgb=%h p=%h ec=%0d ec4=%0d exp all zero",
                     out_valid, out_sof, {outR, outG, outB}, pass_thru, edge_count, edge_count4);
        end
        model_reset();
    endtask

    task automatic test_classic();
        en = 1; mode = 2'd1; edge_thresh = '0; edge_color = '0; cartoon_blur = 24'h112233;
        beat(1, 1, 8'd0);
        beat(1, 0, 8'd5);
        checks++;
        if ({outR, outG, outB} !== 24'h112233) begin
            failures++; $display("FAIL classic_blur got=%h exp=112233", {outR, outG, outB});
        end
        beat(0, 0, 8'd0);
        checks++;
        if ({outR, outG, outB} !== 24'h000000) begin
            failures++; $display("FAIL classic_edge got=%h exp=000000", {outR, outG, outB});
        end
    endtask

    task automatic test_threshold();
        en = 1; mode = 2'd1; edge_thresh = 8'h40; edge_color = 24'hFF0000;
        cartoon_blur = 24'h4A5B6C;
        beat(1, 1, 8'h40);
        beat(1, 0, 8'h41);
        checks++;
        if ({outR, outG, outB} !== 24'h4A5B6C) begin
            failures++; $display("FAIL thresh_equal got=%h exp=4a5b6c", {outR, outG, outB});
        end
        beat(0, 0, 8'h00);
        checks++;
        if ({outR, outG, outB} !== 24'hFF0000) begin
            failures++; $display("FAIL thresh_above got=%h exp=ff0000", {outR, outG, outB});
        end
    endtask

    task automatic test_posterize();
        en = 1; mode = 2'd2; edge_thresh = 8'h10; cartoon_blur = 24'hB71FFF;
        beat(1, 1, 8'h00);
        beat(0, 0, 8'h00);
        checks++;
        if ({outR, outG, outB} !== 24'hB600FF) begin
            failures++; $display("FAIL posterize got=%h exp=b600ff", {outR, outG, outB});
        end
        for (int i = 0; i < 40; i++) begin
            cartoon_blur = 24'($urandom);
            beat(1, 0, EW'($urandom));
        end
    endtask

    task automatic test_shadow();
        en = 1; mode = 2'd1; edge_thresh = 8'h80; edge_color = 24'($urandom);
        cartoon_blur = 24'($urandom);
        beat(1, 1, EW'($urandom));
        for (int i = 0; i < 6; i++) begin
            cartoon_blur = 24'($urandom);
            beat(1, 0, EW'($urandom));
        end
        mode = 2'd3; edge_thresh = 8'h00;
        cartoon_blur = 24'h13579B;
        beat(1, 0, 8'h10);
        beat(0, 1, 8'h10);  // invalid sof must not load
        checks++;
        if ({outR, outG, outB} !== 24'h13579B) begin
            failures++; $display("FAIL shadow_hold got=%h exp=13579b", {outR, outG, outB});
        end
        beat(1, 0, 8'h10);
        beat(1, 1, 8'h00);
        beat(0, 0, 8'h00);
        checks++;
        if ({outR, outG, outB} !== 24'hFFFFFF) begin
            failures++; $display("FAIL shadow_load got=%h exp=ffffff", {outR, outG, outB});
        end
    endtask

    task automatic test_counter();
        bit flags[100];
        bit t;
        int j;
        en = 1; mode = 2'($urandom); edge_thresh = 8'h40; edge_color = 24'($urandom);
        for (int i = 0; i < 100; i++) flags[i] = (i < 37);
        for (int i = 99; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = flags[i]; flags[i] = flags[j]; flags[j] = t;
        end
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0)
                beat(0, 1'($urandom), EW'($urandom_range(8'h41, 8'hFF)));
            cartoon_blur = 24'($urandom);
            beat(1, (i == 0), flags[i] ? EW'($urandom_range(8'h41, 8'hFF))
                                       : EW'($urandom_range(0, 8'h40)));
        end
        beat(1, 1, 8'h00);
        beat(0, 0, 8'h00);
        checks++;
        if (edge_count !== 20'd37) begin
            failures++; $display("FAIL count_37 got=%0d exp=37", edge_count);
        end
        checks++;
        if (edge_count4 !== 4'd15) begin
            failures++; $display("FAIL count_sat37 got=%0d exp=15", edge_count4);
        end
        for (int i = 0; i < 20; i++) beat(1, 0, 8'hFF);
        beat(1, 1, 8'h00);
        beat(0, 0, 8'h00);
        checks++;
        if (edge_count !== 20'd20) begin
            failures++; $display("FAIL count_20 got=%0d exp=20", edge_count);
        end
        checks++;
        if (edge_count4 !== 4'd15) begin
            failures++; $display("FAIL count_sat20 got=%0d exp=15", edge_count4);
        end
    endtask

    task automatic test_en_bypass();
        logic [PW-1:0] p;
        en = 0; mode = 2'd2; edge_thresh = 8'h00; edge_color = 24'hABCDEF;
        in_valid = 1; in_sof = 1; cartoon_edge = 8'hFF;
        r = 8'h12; g = 8'h34; b = 8'h56;
        step();
        p = pass_in;
        beat(0, 0, 8'h00);
        checks++;
        if ({outR, outG, outB} !== 24'h123456) begin
            failures++; $display("FAIL en_bypass got=%h exp=123456", {outR, outG, outB});
        end
        checks++;
        if (pass_thru !== p) begin
            failures++; $display("FAIL pass_delay got=%h exp=%h", pass_thru, p);
        end
        for (int i = 0; i < 30; i++) begin
            cartoon_blur = 24'($urandom);
            beat(1'($urandom), ($urandom_range(0, 9) == 0), EW'($urandom));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 4) != 0);
            mode = 2'($urandom); edge_thresh = EW'($urandom); edge_color = 24'($urandom);
            cartoon_blur = 24'($urandom);
            beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), EW'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        en = 1; mode = 2'd1; edge_thresh = 8'h20;
        beat(1, 1, 8'hFF);
        for (int i = 0; i < 10; i++) beat(1, 0, 8'hFF);
        test_reset();
        // no sof yet: still bypass, edges still counted
        for (int i = 0; i < 8; i++) begin
            cartoon_blur = 24'($urandom);
            beat(1, 0, EW'($urandom));
        end
        mode = 2'd3; edge_thresh = 8'h80;
        beat(1, 1, 8'h00);
        for (int i = 0; i < 5; i++) beat(1, 0, 8'hC0);
        beat(1, 1, 8'h00);
        beat(0, 0, 8'h00);
        checks++;
        if (edge_count !== 20'd5) begin
            failures++; $display("FAIL count_after_reset got=%0d exp=5", edge_count);
        end
    endtask

    initial begin
        test_reset();
        test_classic();
        test_threshold();
        test_posterize();
        test_shadow();
        test_counter();
        test_en_bypass();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cartoon_pipe.md
Name: cartoon_pipe

Overview:
Parametrised, pipelined successor to the combinational cartoon stage in the D8M video path. Per pixel it selects among the camera pixel, the blurred pixel, posterized blur and a configurable edge colour, under a thresholded edge magnitude. Configuration is shadowed at frame start so the output never tears mid-frame. It also keeps a per-frame saturating edge-pixel count for the control/HEX display logic, and sits between the blur/edge generators and the VGA output mux.

Parameters:
DW, 8, bits per colour channel
EW, 8, width of edge magnitude input
QB, 3, posterize bits kept per channel (1..DW)
PW, 24, width of pass-through sideband bus
CW, 20, width of edge-pixel counters

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
en  in  1  effect enable; 0 forces bypass (sampled per pixel, not shadowed)
mode  in  2  0 bypass, 1 classic, 2 posterize-cartoon, 3 edge map
edge_thresh  in  EW  pixel is edge when cartoon_edge > edge_thresh
edge_color  in  3*DW  {R,G,B} colour painted on edge pixels
in_valid  in  1  input pixel qualifier
in_sof  in  1  first pixel of frame, qualified by in_valid
r, g, b  in  DW each  camera pixel
cartoon_edge  in  EW  edge magnitude
cartoon_blur  in  3*DW  blurred pixel {R,G,B}
pass_in  in  PW  sideband (sync/coords), delayed with pixel
out_valid  out  1  output qualifier
out_sof  out  1  frame start, aligned with out_valid
outR, outG, outB  out  DW each  result pixel
pass_thru  out  PW  pass_in delayed to match pixel latency
edge_count  out  CW  edge pixels in last completed frame

Behaviour:
- Single clock clk; rst synchronous, active-high. Reset: out_valid=0, out_sof=0, outR/G/B=0, pass_thru=0, edge_count=0, running counter=0, shadow mode=0, shadow thresh=0, shadow colour=0.
- Latency fixed at 2 cycles for every output incl. pass_thru; no backpressure; pipeline advances every cycle; invalid beats propagate with out_valid=0 and must not affect the counter.
- Shadow regs (mode, edge_thresh, edge_color) load when in_valid&&in_sof; that pixel already uses the new values. Without any sof since reset, shadow values stay at reset (bypass).
- Stage 1: register pixel, blur, pass_in, valid, sof; compute is_edge = cartoon_edge > thresh (unsigned); compute posterized blur per channel: top QB bits replicated down to fill DW (QB=3: 0xB7 -> 0xB6, 0x1F -> 0x00, 0xFF -> 0xFF). QB=DW means identity.
- Stage 2 select (en=0 -> bypass regardless of mode):
  mode0: {r,g,b}.
  mode1: is_edge ? edge_color : blur.
  mode2: is_edge ? edge_color : posterized blur.
  mode3: is_edge ? edge_color : {DW{1'b1}} white.
- With edge_thresh=0 and edge_color=0, mode1 matches the legacy cartoon output exactly.
- Counter: on valid pixel with is_edge (any mode, counted even when en=0), running count +1, saturating at all-ones. On valid sof: edge_count <= running count (excluding the sof pixel), running <= is_edge(sof pixel)?1:0. edge_count updates in the same cycle the sof pixel leaves stage 1.
- Reset mid-frame: pipeline flushed, counters zero; the next frame's edge_count reflects only pixels after reset.

Decomposition:
- Shared package cartoon_pkg: mode localparams (MODE_BYPASS=0, MODE_CLASSIC=1, MODE_POSTER=2, MODE_EDGEMAP=3) and the white constant.
- One sub-module, posterize_ch (DW, QB; combinational truncate+replicate), instantiated three times.

Test Plan:
- Reset then mode1, thresh=0, colour=0, edge=0, blur=0x112233 -> out 0x11/0x22/0x33 two cycles after in_valid; edge=5 -> 0x00/0x00/0x00.
- Threshold: thresh=0x40, colour=0xFF0000; edge=0x40 -> blur; edge=0x41 -> FF/00/00.
- Posterize mode2, QB=3, blur=0xB71FFF, edge=0 -> B6/00/FF.
- Shadowing: change mode 1->3 mid-frame -> output stays mode1 until next in_valid&&in_sof pixel, which uses mode3.
- Counter: frame of 100 valid pixels with 37 edges, invalid beats interleaved -> edge_count=37 after next sof; CW=4 with 20 edges -> 15.
- en=0 in mode2 -> camera r/g/b out, pass_thru equals pass_in delayed 2 cycles; rst mid-frame -> all outputs 0 the following cycle.
